// File: rtl/smart_toilet_dispense_ctrl.sv
// Inlet dosing sequencer: staggered valve pulses, settle wait, sample strobe, done.
// All outputs are registered. Cycle 0 is the cycle after start is sampled. Start is ignored while busy.
module smart_toilet_dispense_ctrl #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [CW-1:0] d1_i,
  input  logic [CW-1:0] d2_i,
  input  logic [CW-1:0] d3_i,
  input  logic [CW-1:0] pulse_len_i,
  input  logic [CW-1:0] settle_len_i,
  output logic          valve1_o,
  output logic          valve2_o,
  output logic          valve3_o,
  output logic          busy_o,
  output logic          sample_strobe_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic          err_o
);

  localparam int TW = CW + 1;
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, DOSE, SETTLE, SAMPLE, FINISH} state_t;

  state_t        state_q;
  logic          rst_sync_q;
  logic [CW-1:0] d1_q, d2_q, d3_q, pulse_q, settle_q, s_q;
  logic [TW-1:0] end_q, t_q;
  logic          valve1_q, valve2_q, valve3_q, busy_q;
  logic          sample_q, done_q, aborted_q, err_q;

  logic [TW-1:0] t_d, end_d;
  logic [CW-1:0] dmax;

  // Window test in CW+1 bits so d + pulse_len never wraps.
  function automatic logic in_win(input logic [TW-1:0] t, input logic [CW-1:0] d,
                                  input logic [CW-1:0] p);
    logic [TW-1:0] lo, hi;
    lo = {1'b0, d};
    hi = {1'b0, d} + {1'b0, p};
    return (lo <= t) && (t < hi);
  endfunction

  always_comb begin
    dmax = d1_i;
    if (d2_i > dmax) dmax = d2_i;
    if (d3_i > dmax) dmax = d3_i;
    end_d = {1'b0, dmax} + {1'b0, pulse_len_i};
    t_d   = t_q + T_ONE;
  end

  // Reset deassertion is delayed one edge so the FSM leaves reset cleanly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_sync_q <= 1'b1;
    else       rst_sync_q <= 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      pulse_q   <= '0;
      settle_q  <= '0;
      s_q       <= '0;
      end_q     <= '0;
      t_q       <= '0;
      valve1_q  <= 1'b0;
      valve2_q  <= 1'b0;
      valve3_q  <= 1'b0;
      busy_q    <= 1'b0;
      sample_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (!rst_sync_q) begin
      sample_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        // FINISH behaves as idle for start so a back-to-back run begins at its closing edge.
        IDLE, FINISH: begin
          state_q <= IDLE;
          if (start_i) begin
            if (pulse_len_i == '0) begin
              err_q <= 1'b1;
            end else begin
              d1_q     <= d1_i;
              d2_q     <= d2_i;
              d3_q     <= d3_i;
              pulse_q  <= pulse_len_i;
              settle_q <= settle_len_i;
              end_q    <= end_d;
              t_q      <= '0;
              busy_q   <= 1'b1;
              valve1_q <= in_win('0, d1_i, pulse_len_i);
              valve2_q <= in_win('0, d2_i, pulse_len_i);
              valve3_q <= in_win('0, d3_i, pulse_len_i);
              state_q  <= DOSE;
            end
          end
        end
        DOSE, SETTLE, SAMPLE: begin
          if (abort_i) begin
            state_q   <= IDLE;
            valve1_q  <= 1'b0;
            valve2_q  <= 1'b0;
            valve3_q  <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
            case (state_q)
              DOSE: begin
                if (t_q == end_q - T_ONE) begin
                  valve1_q <= 1'b0;
                  valve2_q <= 1'b0;
                  valve3_q <= 1'b0;
                  s_q      <= '0;
                  if (settle_q == '0) begin
                    state_q  <= SAMPLE;
                    sample_q <= 1'b1;
                  end else begin
                    state_q <= SETTLE;
                  end
                end else begin
                  t_q      <= t_d;
                  valve1_q <= in_win(t_d, d1_q, pulse_q);
                  valve2_q <= in_win(t_d, d2_q, pulse_q);
                  valve3_q <= in_win(t_d, d3_q, pulse_q);
                end
              end
              SETTLE: begin
                if (s_q == settle_q - C_ONE) begin
                  state_q  <= SAMPLE;
                  sample_q <= 1'b1;
                end else begin
                  s_q <= s_q + C_ONE;
                end
              end
              default: begin
                state_q <= FINISH;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valve1_o        = valve1_q;
  assign valve2_o        = valve2_q;
  assign valve3_o        = valve3_q;
  assign busy_o          = busy_q;
  assign sample_strobe_o = sample_q;
  assign done_o          = done_q;
  assign aborted_o       = aborted_q;
  assign err_o           = err_q;

endmodule
